// File: rtl/alu_pipe.sv
// alu_pipe: two-stage pipelined ALU with valid/ready handshakes on both sides.
// Stage 1 captures operands and op code; stage 2 computes the result and flags
// (Z, N, C, V) and holds them until the consumer takes them. Backpressure stalls
// the pipe without dropping or duplicating beats.
// Optional feature: define ALU_SAT_EN to make ops 1, 2 and 7 saturate on signed
// overflow. By default results wrap around in two's complement.
module alu_pipe #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] q,
  output logic             zero,
  output logic             negative,
  output logic             carry,
  output logic             overflow
);

  localparam int MSB = WIDTH - 1;

  typedef enum logic [2:0] {
    OP_ZERO = 3'd0,
    OP_ADD  = 3'd1,
    OP_SUB  = 3'd2,
    OP_PASS = 3'd3,
    OP_XOR  = 3'd4,
    OP_OR   = 3'd5,
    OP_AND  = 3'd6,
    OP_INC  = 3'd7
  } op_e;

  // Stage 1: captured operands
  logic             s1_valid_q;
  logic [WIDTH-1:0] s1_a_q;
  logic [WIDTH-1:0] s1_b_q;
  op_e              s1_op_q;

  // Stage 2: registered result and flags
  logic             s2_valid_q;
  logic [WIDTH-1:0] res_q;
  logic             zero_q;
  logic             neg_q;
  logic             carry_q;
  logic             ovf_q;

  // Next-state values computed from stage 1
  logic [WIDTH-1:0] res_d;
  logic             carry_d;
  logic             ovf_d;
  logic [WIDTH:0]   sum_w;

  logic s1_adv;
  logic s2_adv;

  // A stage may advance when it is empty or when its downstream neighbour moves.
  assign s2_adv   = !s2_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign in_ready = s1_adv;

  // Result and flag computation for the beat held in stage 1.
  always_comb begin
    // NOTE: every output of this block gets a default first so that no path
    // through the case leaves a value unassigned and infers a latch.
    res_d   = '0;
    carry_d = 1'b0;
    ovf_d   = 1'b0;
    sum_w   = '0;
    unique case (s1_op_q)
      OP_ZERO: res_d = '0;
      OP_ADD: begin
        sum_w   = {1'b0, s1_a_q} + {1'b0, s1_b_q};
        res_d   = sum_w[MSB:0];
        carry_d = sum_w[WIDTH];
        ovf_d   = (s1_a_q[MSB] == s1_b_q[MSB]) && (res_d[MSB] != s1_a_q[MSB]);
      end
      OP_SUB: begin
        sum_w   = {1'b0, s1_a_q} - {1'b0, s1_b_q};
        res_d   = sum_w[MSB:0];
        carry_d = (s1_a_q < s1_b_q);
        ovf_d   = (s1_a_q[MSB] != s1_b_q[MSB]) && (res_d[MSB] != s1_a_q[MSB]);
      end
      OP_PASS: res_d = s1_a_q;
      OP_XOR:  res_d = s1_a_q ^ s1_b_q;
      OP_OR:   res_d = s1_a_q | s1_b_q;
      OP_AND:  res_d = s1_a_q & s1_b_q;
      OP_INC: begin
        sum_w   = {1'b0, s1_a_q} + (WIDTH + 1)'(1);
        res_d   = sum_w[MSB:0];
        carry_d = sum_w[WIDTH];
        ovf_d   = !s1_a_q[MSB] && res_d[MSB];
      end
    endcase
`ifdef ALU_SAT_EN
    // On overflow the true result has the sign of a, so clamp toward it.
    if (ovf_d) begin
      res_d = s1_a_q[MSB] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
  end

  // Stage 1 register: capture a beat whenever the handshake completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values and the two stages shift as one.
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_op_q    <= OP_ZERO;
    end else if (s1_adv) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_a_q  <= a;
        s1_b_q  <= b;
        s1_op_q <= op_e'(sel);
      end
    end
  end

  // Stage 2 register: load results when stage 1 hands over a beat; hold on stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      res_q      <= '0;
      zero_q     <= 1'b0;
      neg_q      <= 1'b0;
      carry_q    <= 1'b0;
      ovf_q      <= 1'b0;
    end else if (s2_adv) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        res_q   <= res_d;
        zero_q  <= (res_d == '0);
        neg_q   <= res_d[MSB];
        carry_q <= carry_d;
        ovf_q   <= ovf_d;
      end
    end
  end

  assign out_valid = s2_valid_q;
  assign q         = res_q;
  assign zero      = zero_q;
  assign negative  = neg_q;
  assign carry     = carry_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe (WIDTH=16): reset, latency/flags, overflow,
// logic ops, backpressure streaming and full-rate random streaming.
module tb_alu_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic [2:0]  sel;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] q;
  logic        zero;
  logic        negative;
  logic        carry;
  logic        overflow;

  int n_pass;
  int n_total;

  logic [15:0] va [100];
  logic [15:0] vb [100];
  logic [2:0]  vs [100];

  alu_pipe #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sel       (sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .q         (q),
    .zero      (zero),
    .negative  (negative),
    .carry     (carry),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Golden model using integer arithmetic: returns {q, Z, N, C, V}.
  function automatic logic [19:0] model(input logic [15:0] x, input logic [15:0] y,
                                        input logic [2:0] s);
    int ua;
    int ub;
    int sa;
    int sb;
    int full;
    int ss;
    logic [15:0] r;
    logic c;
    logic v;
    ua = x;
    ub = y;
    sa = $signed(x);
    sb = $signed(y);
    full = 0;
    ss = 0;
    r = 16'h0000;
    c = 1'b0;
    v = 1'b0;
    case (s)
      3'd1: begin
        full = ua + ub; ss = sa + sb;
        r = full[15:0]; c = (full > 65535); v = (ss > 32767) || (ss < -32768);
      end
      3'd2: begin
        full = ua - ub; ss = sa - sb;
        r = full[15:0]; c = (ua < ub); v = (ss > 32767) || (ss < -32768);
      end
      3'd3: r = x;
      3'd4: r = x ^ y;
      3'd5: r = x | y;
      3'd6: r = x & y;
      3'd7: begin
        full = ua + 1; ss = sa + 1;
        r = full[15:0]; c = (full > 65535); v = (ss > 32767);
      end
      default: r = 16'h0000;
    endcase
`ifdef ALU_SAT_EN
    if (v) r = (ss > 0) ? 16'h7FFF : 16'h8000;
`endif
    return {r, (r == 16'h0000), r[15], c, v};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = 16'h0; b = 16'h0; sel = 3'd0;
    #2;
    n_total++;
    if ({out_valid, q, zero, negative, carry, overflow} !== 21'h0)
      $display("FAIL reset_outputs: got %h want 0",
               {out_valid, q, zero, negative, carry, overflow});
    else n_pass++;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    n_total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL reset_release: in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
    else n_pass++;
  endtask

  // One beat through an empty pipe with out_ready high; checks 2-clk latency.
  task automatic single_beat(input string name, input logic [15:0] xa, input logic [15:0] xb,
                             input logic [2:0] xs, input logic [19:0] want);
    @(posedge clk); #1;
    in_valid = 1'b1; a = xa; b = xb; sel = xs; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_total++;
    if (out_valid !== 1'b0) $display("FAIL %s_early: out_valid=%b want 0", name, out_valid);
    else n_pass++;
    @(posedge clk); #1;
    n_total++;
    if (out_valid !== 1'b1 || {q, zero, negative, carry, overflow} !== want)
      $display("FAIL %s: valid=%b q/ZNCV=%h want %h", name, out_valid,
               {q, zero, negative, carry, overflow}, want);
    else n_pass++;
  endtask

  task automatic test_latency_flags();
    single_beat("add_wrap", 16'hFFFF, 16'h0001, 3'd1, {16'h0000, 4'b1010});
    single_beat("sub_neg",  16'h0003, 16'h0005, 3'd2, {16'hFFFE, 4'b0110});
  endtask

  task automatic test_overflow();
`ifdef ALU_SAT_EN
    single_beat("add_ovf", 16'h7FFF, 16'h0001, 3'd1, {16'h7FFF, 4'b0001});
`else
    single_beat("add_ovf", 16'h7FFF, 16'h0001, 3'd1, {16'h8000, 4'b0101});
`endif
    single_beat("inc_neg", 16'h8000, 16'h1234, 3'd7, {16'h8001, 4'b0100});
  endtask

  task automatic test_logic_ops();
    single_beat("xor",  16'hF0F0, 16'h0FF0, 3'd4, {16'hFF00, 4'b0100});
    single_beat("or",   16'hF0F0, 16'h0FF0, 3'd5, {16'hFFF0, 4'b0100});
    single_beat("and",  16'hF0F0, 16'h0FF0, 3'd6, {16'h00F0, 4'b0000});
    single_beat("zero", 16'hF0F0, 16'h0FF0, 3'd0, {16'h0000, 4'b1000});
  endtask

  // Streams n beats from va/vb/vs; bp selects the 1,0,0,1 out_ready pattern.
  task automatic drive_stream(input string name, input int n, input bit bp);
    int idx;
    int got;
    int cyc;
    int inflight;
    int first_cyc;
    int last_cyc;
    bit held;
    logic [19:0] held_val;
    logic [19:0] obs;
    logic [19:0] want;
    bit acc;
    bit dlv;
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    idx = 0; got = 0; cyc = 0; inflight = 0; held = 1'b0; held_val = '0;
    first_cyc = -1; last_cyc = -1;
    out_ready = bp ? 1'b1 : 1'b1;
    in_valid = 1'b1; a = va[0]; b = vb[0]; sel = vs[0];
    while (got < n && cyc < 2000) begin
      @(negedge clk);
      obs = {q, zero, negative, carry, overflow};
      n_total++;
      if (in_ready !== !(inflight == 2 && !out_ready))
        $display("FAIL %s_in_ready: cyc %0d got %b with %0d in flight", name, cyc, in_ready, inflight);
      else n_pass++;
      if (held) begin
        n_total++;
        if (out_valid !== 1'b1 || obs !== held_val)
          $display("FAIL %s_hold: cyc %0d valid=%b val=%h want %h", name, cyc, out_valid, obs, held_val);
        else n_pass++;
      end
      acc = in_valid && in_ready;
      dlv = out_valid && out_ready;
      if (dlv) begin
        want = model(va[got], vb[got], vs[got]);
        n_total++;
        if (obs !== want) $display("FAIL %s_beat%0d: got %h want %h", name, got, obs, want);
        else n_pass++;
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
        got++;
      end
      held = out_valid && !out_ready;
      held_val = obs;
      if (acc) idx++;
      inflight = inflight + int'(acc) - int'(dlv);
      @(posedge clk); #1;
      cyc++;
      out_ready = bp ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      in_valid = (idx < n);
      if (idx < n) begin
        a = va[idx]; b = vb[idx]; sel = vs[idx];
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    n_total++;
    if (got != n) $display("FAIL %s_timeout: got %0d beats want %0d", name, got, n);
    else n_pass++;
    if (!bp) begin
      n_total++;
      if (first_cyc != 2 || last_cyc - first_cyc != n - 1)
        $display("FAIL %s_rate: first %0d last %0d want first 2 span %0d",
                 name, first_cyc, last_cyc, n - 1);
      else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 10; i++) begin
      va[i] = 16'(i); vb[i] = 16'h0001; vs[i] = 3'd1;
    end
    drive_stream("bp", 10, 1'b1);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 100; i++) begin
      va[i] = 16'($urandom_range(0, 65535));
      vb[i] = 16'($urandom_range(0, 65535));
      vs[i] = 3'($urandom_range(0, 7));
    end
    va[0] = 16'h7FFF; vb[0] = 16'h7FFF; vs[0] = 3'd1;
    va[1] = 16'h8000; vb[1] = 16'h0001; vs[1] = 3'd2;
    va[2] = 16'h7FFF; vs[2] = 3'd7;
    drive_stream("b2b", 100, 1'b0);
  endtask

  task automatic test_reset_midstream();
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid = 1'b1; a = 16'h1234; b = 16'h0001; sel = 3'd1;
    @(posedge clk); #1;
    a = 16'h0010; b = 16'h0001; sel = 3'd2;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_total++;
    if (out_valid !== 1'b1 || q !== 16'h1235 || in_ready !== 1'b0)
      $display("FAIL mid_full: valid=%b q=%h in_ready=%b want 1/1235/0", out_valid, q, in_ready);
    else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_total++;
    if ({out_valid, q, zero, negative, carry, overflow} !== 21'h0)
      $display("FAIL mid_reset: got %h want 0", {out_valid, q, zero, negative, carry, overflow});
    else n_pass++;
    @(negedge clk); rst_n = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      n_total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1)
        $display("FAIL mid_stale%0d: out_valid=%b in_ready=%b want 0/1", i, out_valid, in_ready);
      else n_pass++;
    end
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    test_reset();
    test_latency_flags();
    test_overflow();
    test_logic_ops();
    test_backpressure();
    test_back_to_back();
    test_reset_midstream();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
